csi2_pkt_parser: RTL and testbench
==================================

Name: csi2_pkt_parser

Overview:
- Sits directly downstream of the D-PHY slave and consumes its 32-bit mapped word stream in the byte clock domain.
- Decodes the CSI-2 packet header and checks the header ECC.
- Strips the payload CRC and forwards payload words with byte enables and a last-word flag.
- Pulses an end-of-packet strobe that drives the D-PHY slave's phy_rst_i, so lane/word alignment re-arms for the next HS burst.

Parameters:
- VC_FILTER_EN, 0: when 1, only packets whose VC equals VC_ID produce payload/header outputs; other packets are still parsed and generate eop_o.
- VC_ID, 0: virtual channel accepted when VC_FILTER_EN = 1 (2 bits).

Ports:
- clk_i  in  1  byte clock (the D-PHY slave's clk_o)
- rst_n_i  in  1  asynchronous active-low reset
- data_i  in  32  mapped word; byte0 = [7:0]
- valid_i  in  1  data_i qualifier; gaps allowed
- hdr_valid_o  out  1  one-cycle pulse; header accepted
- vc_o  out  2  virtual channel, held until next header
- dt_o  out  6  data type, held until next header
- wc_o  out  16  word count / short-packet data, held until next header
- short_pkt_o  out  1  qualifies hdr_valid_o; DT <= 0x0F
- tdata_o  out  32  payload word
- tkeep_o  out  4  valid payload bytes, LSB-first contiguous
- tvalid_o  out  1  payload qualifier; no backpressure
- tlast_o  out  1  last payload word of the packet
- eop_o  out  1  one-cycle pulse; packet finished or aborted
- ecc_err_o  out  1  one-cycle pulse; uncorrectable header
- ecc_corr_o  out  1  one-cycle pulse; single-bit error corrected (optional feature only)

Behaviour:
- Async reset (rst_n_i low): state IDLE; all outputs 0; vc/dt/wc registers 0; byte counter 0. Reset mid-packet discards the packet and produces no eop_o.
- All outputs are registered: 1 cycle latency from the valid_i word to its effect. Only cycles with valid_i = 1 advance the FSM.
- Header word layout: DI = [7:0] (VC [7:6], DT [5:0]); WC = [23:8], little-endian; ECC = [29:24]; [31:30] are ignored.
- ECC is the CSI-2 6-bit Hamming code over the 24 header bits. Syndrome = received ECC XOR computed ECC.
- IDLE, valid word:
  - Syndrome 0: latch vc/dt/wc; hdr_valid_o = 1.
  - Syndrome nonzero: ecc_err_o = 1 and eop_o = 1; no hdr_valid_o; remain in IDLE.
  - Short packet with good header: eop_o = 1 in the same cycle as hdr_valid_o; remain in IDLE.
  - Long packet, WC > 0: load rem = WC; go to PAYLOAD.
  - Long packet, WC = 0: go to CRC (one 2-byte CRC word follows).
- PAYLOAD, valid word:
  - tvalid_o = 1, tdata_o = data_i.
  - rem > 4: tkeep_o = 4'hF; rem -= 4.
  - rem <= 4: tkeep_o = (1 << rem) - 1; tlast_o = 1.
  - Then, if rem + 2 <= 4 (CRC fits in this word): eop_o = 1 and go to IDLE. Otherwise go to CRC.
- CRC, valid word: word discarded; eop_o = 1; go to IDLE.
- Counter width: 17 bits, so WC = 0xFFFF is handled without overflow.
- VC filter miss: tvalid_o, tlast_o and hdr_valid_o are suppressed; the FSM and eop_o are unchanged.
- No tready: a downstream stall is not supported and must be absorbed by a FIFO downstream.
- eop_o is asserted at most once per packet; eop_o and tlast_o may coincide.

Optional Feature:
- Macro: CSI2_ECC_CORRECT_EN.
- Defined: a syndrome that matches a single header-bit or ECC-bit column is corrected. The corrected DI/WC are used, ecc_corr_o pulses with hdr_valid_o, and the packet proceeds normally. Any other nonzero syndrome takes the ecc_err_o path.
- Undefined: any nonzero syndrome takes the ecc_err_o path. ecc_corr_o is tied to 0.

Test Plan:
- Short packet, frame start: DI = 0x00, WC = 0x0001, valid ECC -> next cycle hdr_valid_o = 1, short_pkt_o = 1, dt_o = 0x00, wc_o = 1, eop_o = 1; no tvalid_o.
- Long packet: DT = 0x2A, WC = 10, then 3 words -> tvalid_o x3 with tkeep_o = F, F, 3; tlast_o on word 3; eop_o on word 3 (10 + 2 = 12 bytes, exactly 3 words).
- Long packet, WC = 4 -> one payload word with tkeep_o = F and tlast_o; the CRC-only second word is dropped; eop_o on that second word.
- Long packet, WC = 0 -> hdr_valid_o, no payload, eop_o on the following word. Also insert valid_i gaps of 3 cycles mid-payload (WC = 10) -> same output sequence as the gap-free case.
- Header with ECC bit 26 flipped:
  - Without the macro: ecc_err_o = 1, eop_o = 1, no hdr_valid_o.
  - With CSI2_ECC_CORRECT_EN: ecc_corr_o = 1, hdr_valid_o = 1, payload forwarded.
  - Two flipped bits: ecc_err_o = 1 in both builds.
- Assert rst_n_i mid-payload of a WC = 100 packet -> all outputs 0 immediately. A following good short packet is parsed correctly from IDLE.

Source files
------------

// File: rtl/csi2_pkt_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : csi2_pkt_parser                                               |
// | Purpose  : CSI-2 packet parser behind the D-PHY slave. It decodes and    |
// |            ECC-checks the packet header, strips the payload CRC, and     |
// |            forwards payload words with byte enables and a last flag.     |
// |            eop_o re-arms the D-PHY slave word alignment.                 |
// | Ports    : clk_i, rst_n_i       byte clock, async active-low reset        |
// |            data_i, valid_i      32-bit mapped word stream (byte0=[7:0])   |
// |            hdr_valid_o, vc_o, dt_o, wc_o, short_pkt_o   header outputs   |
// |            tdata_o, tkeep_o, tvalid_o, tlast_o  payload (no backpressure)|
// |            eop_o, ecc_err_o, ecc_corr_o         status pulses            |
// | Options  : `define CSI2_ECC_CORRECT_EN enables single-bit header         |
// |            correction; without it ecc_corr_o is constant 0.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module csi2_pkt_parser #(
  parameter int         VC_FILTER_EN = 0,
  parameter logic [1:0] VC_ID        = 2'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        hdr_valid_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic        short_pkt_o,
  output logic [31:0] tdata_o,
  output logic [3:0]  tkeep_o,
  output logic        tvalid_o,
  output logic        tlast_o,
  output logic        eop_o,
  output logic        ecc_err_o,
  output logic        ecc_corr_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } state_t;

  // Parity-check column of each header bit in the CSI-2 Hamming code.
  function automatic logic [5:0] ecc_col(input logic [4:0] idx);
    case (idx)
      5'd0:  ecc_col = 6'h07;  5'd1:  ecc_col = 6'h0B;  5'd2:  ecc_col = 6'h0D;
      5'd3:  ecc_col = 6'h0E;  5'd4:  ecc_col = 6'h13;  5'd5:  ecc_col = 6'h15;
      5'd6:  ecc_col = 6'h16;  5'd7:  ecc_col = 6'h19;  5'd8:  ecc_col = 6'h1A;
      5'd9:  ecc_col = 6'h1C;  5'd10: ecc_col = 6'h23;  5'd11: ecc_col = 6'h25;
      5'd12: ecc_col = 6'h26;  5'd13: ecc_col = 6'h29;  5'd14: ecc_col = 6'h2A;
      5'd15: ecc_col = 6'h2C;  5'd16: ecc_col = 6'h31;  5'd17: ecc_col = 6'h32;
      5'd18: ecc_col = 6'h34;  5'd19: ecc_col = 6'h38;  5'd20: ecc_col = 6'h1F;
      5'd21: ecc_col = 6'h2F;  5'd22: ecc_col = 6'h37;  5'd23: ecc_col = 6'h3B;
      default: ecc_col = 6'h00;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [16:0]   rem_q, rem_d;
  logic          pass_q, pass_d;
  logic [1:0]    vc_q, vc_d;
  logic [5:0]    dt_q, dt_d;
  logic [15:0]   wc_q, wc_d;
  logic          short_q, short_d;
  logic          hdr_valid_q, hdr_valid_d;
  logic [31:0]   tdata_q, tdata_d;
  logic [3:0]    tkeep_q, tkeep_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          eop_q, eop_d;
  logic          ecc_err_q, ecc_err_d;
  logic          ecc_corr_q, ecc_corr_d;

  logic [23:0]   hdr_raw;
  logic [23:0]   hdr_fix;
  logic [5:0]    ecc_calc;
  logic [5:0]    syn;
  logic          fix_ok;
  logic          hdr_good;
  logic          vc_pass;
  logic          unused_bits;

  assign hdr_raw     = data_i[23:0];
  assign unused_bits = ^data_i[31:30];

  always_comb begin
    ecc_calc = 6'd0;
    for (int i = 0; i < 24; i++) begin
      if (hdr_raw[i]) ecc_calc = ecc_calc ^ ecc_col(5'(i));
    end
  end

  assign syn = data_i[29:24] ^ ecc_calc;

  // A syndrome equal to a data column flips that header bit; a single-bit
  // syndrome means only the ECC field was hit, so the header is intact.
  always_comb begin
    hdr_fix = hdr_raw;
    fix_ok  = 1'b0;
`ifdef CSI2_ECC_CORRECT_EN
    for (int i = 0; i < 24; i++) begin
      if (syn == ecc_col(5'(i))) begin
        hdr_fix[i] = ~hdr_raw[i];
        fix_ok     = 1'b1;
      end
    end
    if ((syn != 6'd0) && ((syn & (syn - 6'd1)) == 6'd0)) fix_ok = 1'b1;
`endif
  end

  assign hdr_good = (syn == 6'd0) || fix_ok;
  assign vc_pass  = (VC_FILTER_EN == 0) || (hdr_fix[7:6] == VC_ID);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pass_d      = pass_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    short_d     = short_q;
    tdata_d     = tdata_q;
    tkeep_d     = 4'h0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    hdr_valid_d = 1'b0;
    eop_d       = 1'b0;
    ecc_err_d   = 1'b0;
    ecc_corr_d  = 1'b0;
    if (valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (!hdr_good) begin
            ecc_err_d = 1'b1;
            eop_d     = 1'b1;
          end else begin
            pass_d = vc_pass;
            if (vc_pass) begin
              hdr_valid_d = 1'b1;
              ecc_corr_d  = (syn != 6'd0);
              vc_d        = hdr_fix[7:6];
              dt_d        = hdr_fix[5:0];
              wc_d        = hdr_fix[23:8];
              short_d     = (hdr_fix[5:0] <= 6'h0F);
            end
            if (hdr_fix[5:0] <= 6'h0F) begin
              eop_d = 1'b1;
            end else if (hdr_fix[23:8] != 16'd0) begin
              rem_d   = {1'b0, hdr_fix[23:8]};
              state_d = ST_PAYLOAD;
            end else begin
              state_d = ST_CRC;
            end
          end
        end
        ST_PAYLOAD: begin
          tvalid_d = pass_q;
          if (pass_q) tdata_d = data_i;
          if (rem_q > 17'd4) begin
            tkeep_d = pass_q ? 4'hF : 4'h0;
            rem_d   = rem_q - 17'd4;
          end else begin
            case (rem_q[2:0])
              3'd1:    tkeep_d = 4'h1;
              3'd2:    tkeep_d = 4'h3;
              3'd3:    tkeep_d = 4'h7;
              default: tkeep_d = 4'hF;
            endcase
            if (!pass_q) tkeep_d = 4'h0;
            tlast_d = pass_q;
            // Both CRC bytes fit behind the last payload byte in this word.
            if (rem_q <= 17'd2) begin
              eop_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_CRC;
            end
          end
        end
        ST_CRC: begin
          eop_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      rem_q       <= 17'd0;
      pass_q      <= 1'b0;
      vc_q        <= 2'd0;
      dt_q        <= 6'd0;
      wc_q        <= 16'd0;
      short_q     <= 1'b0;
      hdr_valid_q <= 1'b0;
      tdata_q     <= 32'd0;
      tkeep_q     <= 4'h0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      eop_q       <= 1'b0;
      ecc_err_q   <= 1'b0;
      ecc_corr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      pass_q      <= pass_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      short_q     <= short_d;
      hdr_valid_q <= hdr_valid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      eop_q       <= eop_d;
      ecc_err_q   <= ecc_err_d;
      ecc_corr_q  <= ecc_corr_d;
    end
  end

  assign hdr_valid_o = hdr_valid_q;
  assign vc_o        = vc_q;
  assign dt_o        = dt_q;
  assign wc_o        = wc_q;
  assign short_pkt_o = short_q;
  assign tdata_o     = tdata_q;
  assign tkeep_o     = tkeep_q;
  assign tvalid_o    = tvalid_q;
  assign tlast_o     = tlast_q;
  assign eop_o       = eop_q;
  assign ecc_err_o   = ecc_err_q;
  assign ecc_corr_o  = ecc_corr_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2_pkt_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_csi2_pkt_parser                                            |
// | Purpose  : Scoreboard bench for csi2_pkt_parser. Every driven cycle      |
// |            pushes the expected registered outputs; a monitor pops and    |
// |            compares them one clock later.                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_csi2_pkt_parser;

  logic        clk_i   = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] data_i  = 32'd0;
  logic        valid_i = 1'b0;
  logic        hdr_valid_o, short_pkt_o, tvalid_o, tlast_o, eop_o, ecc_err_o, ecc_corr_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic [31:0] tdata_o;
  logic [3:0]  tkeep_o;

  always #5 clk_i = ~clk_i;

  csi2_pkt_parser #(.VC_FILTER_EN(0), .VC_ID(2'd0)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .hdr_valid_o(hdr_valid_o), .vc_o(vc_o), .dt_o(dt_o), .wc_o(wc_o),
    .short_pkt_o(short_pkt_o), .tdata_o(tdata_o), .tkeep_o(tkeep_o),
    .tvalid_o(tvalid_o), .tlast_o(tlast_o), .eop_o(eop_o),
    .ecc_err_o(ecc_err_o), .ecc_corr_o(ecc_corr_o)
  );

  typedef struct {
    logic        hdr, shrt;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        tv;
    logic [3:0]  tk;
    logic [31:0] td;
    logic        tl, eop, err, corr;
    time         t;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          eop_seen = 0;
  int          beats_seen = 0;
  logic [1:0]  h_vc = 2'd0;
  logic [5:0]  h_dt = 6'd0;
  logic [15:0] h_wc = 16'd0;

  // CSI-2 header ECC written out as its six parity equations.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] mkhdr(input logic [1:0] vc, input logic [5:0] dt,
                                        input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, vc, dt};
    return {2'b00, ecc6(d), d};
  endfunction

  function automatic exp_t mk();
    exp_t e;
    e = '{default: 0};
    e.vc = h_vc;
    e.dt = h_dt;
    e.wc = h_wc;
    return e;
  endfunction

  task automatic drive(input logic [31:0] d, input logic v, input exp_t e);
    @(posedge clk_i);
    #1;
    data_i  = d;
    valid_i = v;
    e.t     = $time;
    q.push_back(e);
  endtask

  task automatic flush();
    drive($urandom, 1'b0, mk());
    drive($urandom, 1'b0, mk());
    @(negedge clk_i);
    #1;
  endtask

  // Long packet: header, ceil(wc/4) payload words, and the CRC word if the
  // two CRC bytes spill past the last payload word.
  task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input int wc,
                           input int gap, input logic [31:0] flip);
    exp_t e;
    int   n_pay, n_tot, bytes;
    logic [31:0] w;
    h_vc = vc; h_dt = dt; h_wc = 16'(wc);
    e = mk();
    e.hdr  = 1'b1;
    e.corr = (flip != 32'd0);
    drive(mkhdr(vc, dt, 16'(wc)) ^ flip, 1'b1, e);
    n_pay = (wc + 3) / 4;
    n_tot = (wc + 2 + 3) / 4;
    for (int k = 0; k < n_tot; k++) begin
      w = $urandom;
      e = mk();
      if (k < n_pay) begin
        bytes = wc - 4 * k;
        e.tv  = 1'b1;
        e.td  = w;
        e.tk  = (bytes >= 4) ? 4'hF : (4'hF >> (4 - bytes));
        e.tl  = (k == n_pay - 1);
      end
      e.eop = (k == n_tot - 1);
      drive(w, 1'b1, e);
      if (k < n_tot - 1) repeat (gap) drive($urandom, 1'b0, mk());
    end
  endtask

  task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    exp_t e;
    h_vc = vc; h_dt = dt; h_wc = wc;
    e = mk();
    e.hdr = 1'b1; e.shrt = 1'b1; e.eop = 1'b1;
    drive(mkhdr(vc, dt, wc), 1'b1, e);
  endtask

  // Scoreboard monitor: entries pushed before the last rising edge are due.
  always @(negedge clk_i) begin
    exp_t        e;
    logic [66:0] a, x;
    if (rst_n_i && q.size() > 0 && ($time - q[0].t) >= 10) begin
      e = q.pop_front();
      a = {hdr_valid_o, e.hdr ? short_pkt_o : 1'b0, vc_o, dt_o, wc_o, tvalid_o,
           e.tv ? tkeep_o : 4'h0, e.tv ? tdata_o : 32'h0, tlast_o, eop_o, ecc_err_o, ecc_corr_o};
      x = {e.hdr, e.hdr ? e.shrt : 1'b0, e.vc, e.dt, e.wc, e.tv,
           e.tk, e.td, e.tl, e.eop, e.err, e.corr};
      checks++;
      if (a !== x)
        $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, x);
      else
        passed++;
    end
    if (eop_o) eop_seen++;
    if (tvalid_o) beats_seen++;
  end

  task automatic test_reset();
    #1;
    checks++;
    if ({hdr_valid_o, vc_o, dt_o, wc_o, short_pkt_o, tdata_o, tkeep_o, tvalid_o, tlast_o,
         eop_o, ecc_err_o, ecc_corr_o} !== 69'd0)
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    else passed++;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
  endtask

  task automatic test_short_pkt();
    int e0 = eop_seen;
    send_short(2'd0, 6'h00, 16'h0001);
    flush();
    checks++;
    if (eop_seen - e0 !== 1) $display("FAIL short_eop_count: got %0d required 1", eop_seen - e0);
    else passed++;
  endtask

  task automatic test_long(input int wc, input int gap, input int beats, input string nm);
    int e0 = eop_seen, b0 = beats_seen;
    send_long(2'd1, 6'h2A, wc, gap, 32'd0);
    flush();
    checks++;
    if ((eop_seen - e0 !== 1) || (beats_seen - b0 !== beats))
      $display("FAIL %s: got eop %0d beats %0d required eop 1 beats %0d",
               nm, eop_seen - e0, beats_seen - b0, beats);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int e0 = eop_seen;
    send_short(2'd3, 6'h01, 16'h1234);
    send_long(2'd2, 6'h24, 5, 0, 32'd0);
    send_long(2'd0, 6'h2B, 7, 0, 32'd0);
    send_short(2'd1, 6'h02, 16'hFFFF);
    flush();
    checks++;
    if (eop_seen - e0 !== 4) $display("FAIL b2b_eop_count: got %0d required 4", eop_seen - e0);
    else passed++;
  endtask

  task automatic test_ecc();
    exp_t e;
    int   e0 = eop_seen, b0 = beats_seen, want_b;
`ifdef CSI2_ECC_CORRECT_EN
    send_long(2'd0, 6'h2B, 8, 0, 32'h0400_0000);
    want_b = 2;
`else
    e = mk(); e.err = 1'b1; e.eop = 1'b1;
    drive(mkhdr(2'd0, 6'h2B, 16'd8) ^ 32'h0400_0000, 1'b1, e);
    want_b = 0;
`endif
    e = mk(); e.err = 1'b1; e.eop = 1'b1;
    drive(mkhdr(2'd0, 6'h01, 16'h1234) ^ 32'h0C00_0000, 1'b1, e);
    flush();
    checks++;
    if ((eop_seen - e0 !== 2) || (beats_seen - b0 !== want_b))
      $display("FAIL ecc_counts: got eop %0d beats %0d required eop 2 beats %0d",
               eop_seen - e0, beats_seen - b0, want_b);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   e0;
    logic [31:0] w;
    h_vc = 2'd0; h_dt = 6'h2A; h_wc = 16'd100;
    e = mk(); e.hdr = 1'b1;
    drive(mkhdr(2'd0, 6'h2A, 16'd100), 1'b1, e);
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      e = mk(); e.tv = 1'b1; e.td = w; e.tk = 4'hF;
      drive(w, 1'b1, e);
    end
    e0 = eop_seen;
    drive($urandom, 1'b0, mk());
    @(negedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    q.delete();
    h_vc = 2'd0; h_dt = 6'd0; h_wc = 16'd0;
    checks++;
    if ({hdr_valid_o, vc_o, dt_o, wc_o, short_pkt_o, tdata_o, tkeep_o, tvalid_o, tlast_o,
         eop_o, ecc_err_o, ecc_corr_o} !== 69'd0)
      $display("FAIL reset_mid_outputs: got nonzero outputs, required all 0");
    else passed++;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    send_short(2'd1, 6'h03, 16'hBEEF);
    flush();
    checks++;
    if (eop_seen - e0 !== 1) $display("FAIL reset_mid_eop: got %0d required 1", eop_seen - e0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_short_pkt();
    test_long(10, 0, 3, "long_wc10");
    test_long(4, 0, 1, "long_wc4");
    test_long(0, 0, 0, "long_wc0");
    test_long(10, 3, 3, "long_wc10_gaps");
    test_long(13, 1, 4, "long_wc13_gaps");
    test_back_to_back();
    test_ecc();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
